register_file_bank: RTL and testbench
=====================================

// Module: register_file_bank
// PURPOSE
//  Responder end of the PortIn_RegFile/PortOut_RegFile interface: the actual frost32 GPR storage.
//  Decode/register-read drives the selects; writeback drives write_sel/write_data/write_en.
//  Provides 3 registered read ports and 1 write port. r0 reads as zero.
//  Includes a clear sequencer that zeroes all entries after reset or on request.
// PARAMETERS
//  SEL_WIDTH    4   register select width; entry count = 2**SEL_WIDTH (16)
//  DATA_WIDTH   32  register data width
// PORTS
//  clk            in   1           clock, all state on posedge
//  rst_n          in   1           async active-low reset
//  read_sel_ra    in   SEL_WIDTH   read select, port A
//  read_sel_rb    in   SEL_WIDTH   read select, port B
//  read_sel_rc    in   SEL_WIDTH   read select, port C
//  write_sel      in   SEL_WIDTH   write select
//  write_data     in   DATA_WIDTH  write data
//  write_en       in   1           write request, sampled on posedge
//  clear_req      in   1           one-cycle pulse: start soft clear of all entries
//  read_data_ra   out  DATA_WIDTH  registered read data, port A
//  read_data_rb   out  DATA_WIDTH  registered read data, port B
//  read_data_rc   out  DATA_WIDTH  registered read data, port C
//  busy           out  1           high while clear sequence runs
//  write_dropped  out  1           one-cycle pulse: a write_en was ignored
// BEHAVIOUR
//  Reset (rst_n=0, async): all read_data_* = 0, write_dropped = 0, busy = 1,
//   FSM = CLEARING, clear_idx = 0. Array contents are not reset directly.
//  FSM states: CLEARING, READY.
//  CLEARING: each posedge writes 0 to entry[clear_idx], then clear_idx += 1.
//   After entry 2**SEL_WIDTH-1 is written (16 cycles), go to READY and drop busy
//   on that same edge. clear_idx wraps to 0.
//  READY: clear_req=1 -> go to CLEARING with clear_idx = 0; busy rises on the next edge.
//  Writes: on posedge when FSM==READY, write_en=1, clear_req=0, and write_sel!=0,
//   set entry[write_sel] <= write_data.
//   Writes to r0 are silently discarded. write_dropped stays 0 for them.
//  Dropped write: write_en=1 while FSM==CLEARING, or together with clear_req,
//   gives write_dropped=1 for exactly the next cycle. clear_req wins over a same-cycle write.
//  Reads: latency 1. read_data_x at edge N+1 = entry[read_sel_x] sampled at edge N.
//   Sel 0 always yields 0.
//   While FSM==CLEARING, all read_data_* register 0.
//   Ports are independent; equal selects on multiple ports are legal.
//  Read/write same edge, same nonzero sel: see CONFIGURATION.
//  clear_req while already CLEARING: ignored; the sweep is not restarted.
//  rst_n asserted mid-sweep: immediate return to reset state; the sweep restarts at 0.
// CONFIGURATION
//  `REG_FILE_BYPASS_EN defined: write-first behaviour.
//   A read at edge N whose sel matches an accepted write at edge N returns write_data.
//   Each port bypasses independently.
//  `REG_FILE_BYPASS_EN undefined: read-first behaviour. Such a read returns the
//   pre-write value; the new value is visible from the read at edge N+1.
//  A dropped write is never bypassed in either mode.
// TESTING
//  1. Release rst_n -> busy=1 for 16 cycles, then 0; all ports read 0 for sels 0..15.
//  2. Write r5=0xDEADBEEF, then read ra=5 -> read_data_ra=0xDEADBEEF one cycle later.
//  3. Write r0=0x00001234, then read rb=0 -> read_data_rb=0, write_dropped=0.
//  4. Same cycle: write r3=0xA5A5A5A5 and read rc=3 (r3 was 0x11111111)
//     -> next cycle read_data_rc=0xA5A5A5A5 with BYPASS_EN, 0x11111111 without.
//  5. r7=0x0BADF00D; pulse clear_req together with write r7=0x1
//     -> write_dropped=1 for 1 cycle, busy=1 for 16 cycles; afterwards r7 reads 0.
//  6. Assert rst_n at clear_idx=8 for 2 cycles, then release
//     -> outputs 0 immediately; busy stays high a full 16 cycles after release.

Source files
------------

// File: rtl/register_file_bank.sv
// -----------------------------------------------------------------------------
// register_file_bank
//   General-purpose register storage for the frost32 core.
//   - 3 registered read ports (A/B/C), read latency of one clock.
//   - 1 write port, driven by writeback.
//   - r0 is hard-wired to zero: writes to it are discarded and reads return 0.
//   - A clear sequencer zeroes every entry, one entry per clock. It runs after
//     reset and again whenever clear_req is pulsed while idle.
//
// Configuration macro:
//   REG_FILE_BYPASS_EN  defined   -> write-first: a read whose select matches
//                                     an accepted same-edge write returns
//                                     write_data.
//                       undefined -> read-first: such a read returns the
//                                     pre-write value.
//
// Ports:
//   clk            in   clock, all state updates on posedge
//   rst_n          in   asynchronous active-low reset
//   read_sel_ra/rb/rc  in   read selects for ports A/B/C
//   write_sel      in   write select
//   write_data     in   write data
//   write_en       in   write request, sampled on posedge
//   clear_req      in   one-cycle pulse that starts a soft clear of all entries
//   read_data_ra/rb/rc out  registered read data for ports A/B/C
//   busy           out  high while the clear sequence runs (mirrors FSM state)
//   write_dropped  out  one-cycle pulse: a write_en was ignored
//
// Handshake: write_en has no ready. It is a request sampled on each posedge.
//   It is accepted when the bank is READY, clear_req is low and write_sel is
//   nonzero. A write refused because of clearing or clear_req is reported by a
//   one-cycle write_dropped pulse. Writes to r0 are discarded silently.
// -----------------------------------------------------------------------------
module register_file_bank #(
  parameter int SEL_WIDTH  = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [SEL_WIDTH-1:0]  read_sel_ra,
  input  logic [SEL_WIDTH-1:0]  read_sel_rb,
  input  logic [SEL_WIDTH-1:0]  read_sel_rc,
  input  logic [SEL_WIDTH-1:0]  write_sel,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  write_en,
  input  logic                  clear_req,
  output logic [DATA_WIDTH-1:0] read_data_ra,
  output logic [DATA_WIDTH-1:0] read_data_rb,
  output logic [DATA_WIDTH-1:0] read_data_rc,
  output logic                  busy,
  output logic                  write_dropped
);

  localparam int ENTRIES = 2 ** SEL_WIDTH;

  typedef enum logic {
    CLEARING = 1'b0,
    READY    = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [SEL_WIDTH-1:0]   clear_idx_q, clear_idx_d;
  logic [DATA_WIDTH-1:0]  mem [ENTRIES];

  logic                   wr_accept;
  logic                   wr_drop;
  logic                   mem_we;
  logic [SEL_WIDTH-1:0]   mem_waddr;
  logic [DATA_WIDTH-1:0]  mem_wdata;
  logic [DATA_WIDTH-1:0]  rd_a_d, rd_b_d, rd_c_d;

  // Value a read port registers on this edge. Clearing and r0 force zero.
  function automatic logic [DATA_WIDTH-1:0] read_value(input logic [SEL_WIDTH-1:0] sel);
    logic [DATA_WIDTH-1:0] v;
    v = '0;
    if (state_q == READY && sel != '0) begin
`ifdef REG_FILE_BYPASS_EN
      if (wr_accept && sel == write_sel) v = write_data;
      else                               v = mem[sel];
`else
      v = mem[sel];
`endif
    end
    return v;
  endfunction

  // Next-state, clear sweep and write-port steering.
  always_comb begin
    state_d     = state_q;
    clear_idx_d = clear_idx_q;
    wr_accept   = 1'b0;
    wr_drop     = 1'b0;
    mem_we      = 1'b0;
    mem_waddr   = '0;
    mem_wdata   = '0;

    case (state_q)
      CLEARING: begin
        mem_we      = 1'b1;
        mem_waddr   = clear_idx_q;
        clear_idx_d = clear_idx_q + 1'b1;     // wraps to 0 after the last entry
        wr_drop     = write_en;
        if (clear_idx_q == {SEL_WIDTH{1'b1}}) state_d = READY;
      end
      READY: begin
        if (clear_req) begin
          // clear_req beats a same-cycle write; the write is reported dropped.
          state_d     = CLEARING;
          clear_idx_d = '0;
          wr_drop     = write_en;
        end else if (write_en && write_sel != '0) begin
          wr_accept = 1'b1;
          mem_we    = 1'b1;
          mem_waddr = write_sel;
          mem_wdata = write_data;
        end
      end
      default: state_d = CLEARING;
    endcase

    rd_a_d = read_value(read_sel_ra);
    rd_b_d = read_value(read_sel_rb);
    rd_c_d = read_value(read_sel_rc);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= CLEARING;
      clear_idx_q   <= '0;
      read_data_ra  <= '0;
      read_data_rb  <= '0;
      read_data_rc  <= '0;
      write_dropped <= 1'b0;
    end else begin
      state_q       <= state_d;
      clear_idx_q   <= clear_idx_d;
      read_data_ra  <= rd_a_d;
      read_data_rb  <= rd_b_d;
      read_data_rc  <= rd_c_d;
      write_dropped <= wr_drop;
    end
  end

  // Storage has no reset; the clear sweep initialises it.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  assign busy = (state_q == CLEARING);

endmodule

// File: tb/tb_register_file_bank.sv
module tb_register_file_bank;

  localparam int SW    = 4;
  localparam int DW    = 32;
  localparam int N     = 16;
  localparam int EXP_W = 3 * DW + 2;

`ifdef REG_FILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [SW-1:0] read_sel_ra = '0, read_sel_rb = '0, read_sel_rc = '0, write_sel = '0;
  logic [DW-1:0] write_data = '0;
  logic          write_en = 1'b0, clear_req = 1'b0;
  logic [DW-1:0] read_data_ra, read_data_rb, read_data_rc;
  logic          busy, write_dropped;

  register_file_bank #(.SEL_WIDTH(SW), .DATA_WIDTH(DW)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .read_sel_ra   (read_sel_ra),
    .read_sel_rb   (read_sel_rb),
    .read_sel_rc   (read_sel_rc),
    .write_sel     (write_sel),
    .write_data    (write_data),
    .write_en      (write_en),
    .clear_req     (clear_req),
    .read_data_ra  (read_data_ra),
    .read_data_rb  (read_data_rb),
    .read_data_rc  (read_data_rc),
    .busy          (busy),
    .write_dropped (write_dropped)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [EXP_W-1:0] exp_q[$];

  // Reference model: register contents plus how many clear cycles remain.
  logic [DW-1:0] model_mem [N];
  int            clear_left;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reset puts the bank into a fresh 16-cycle clear; contents become zero.
  task automatic model_reset();
    for (int i = 0; i < N; i++) model_mem[i] = '0;
    clear_left = N;
  endtask

  function automatic logic [DW-1:0] model_read(input logic [SW-1:0] sel, input bit clearing,
                                               input bit accept, input logic [SW-1:0] ws,
                                               input logic [DW-1:0] wd);
    if (clearing || sel == 0)        return '0;
    if (BYPASS && accept && sel == ws) return wd;
    return model_mem[sel];
  endfunction

  // Driver: called at a negedge; drives one cycle, predicts the response of
  // the coming posedge, then waits for the next negedge.
  task automatic cycle(input logic [SW-1:0] ra, input logic [SW-1:0] rb, input logic [SW-1:0] rc,
                       input logic [SW-1:0] ws, input logic [DW-1:0] wd,
                       input logic we, input logic cr);
    bit clearing, accept, dropped;
    logic [DW-1:0] ea, eb, ec;
    read_sel_ra = ra; read_sel_rb = rb; read_sel_rc = rc;
    write_sel = ws; write_data = wd; write_en = we; clear_req = cr;

    clearing = (clear_left > 0);
    accept   = !clearing && we && !cr && (ws != 0);
    dropped  = we && (clearing || cr);
    ea = model_read(ra, clearing, accept, ws, wd);
    eb = model_read(rb, clearing, accept, ws, wd);
    ec = model_read(rc, clearing, accept, ws, wd);

    if (clearing) begin
      clear_left--;
    end else if (cr) begin
      model_reset();
    end else if (accept) begin
      model_mem[ws] = wd;
    end
    exp_q.push_back({ea, eb, ec, dropped, (clear_left > 0)});
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle('0, '0, '0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_a"}, read_data_ra, '0);
    check({tag, "_rd_b"}, read_data_rb, '0);
    check({tag, "_rd_c"}, read_data_rc, '0);
    check({tag, "_busy"}, {31'b0, busy}, 32'd1);
    check({tag, "_dropped"}, {31'b0, write_dropped}, 32'd0);
  endtask

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    logic [EXP_W-1:0] e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("read_data_ra", read_data_ra, e[EXP_W-1 -: DW]);
      check("read_data_rb", read_data_rb, e[EXP_W-1-DW -: DW]);
      check("read_data_rc", read_data_rc, e[EXP_W-1-2*DW -: DW]);
      check("write_dropped", {31'b0, write_dropped}, {31'b0, e[1]});
      check("busy", {31'b0, busy}, {31'b0, e[0]});
    end
  end

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1, "timeout");
  end

  // ---------------- stimulus ----------------
  initial begin
    model_reset();
    @(negedge clk);
    @(negedge clk);
    check_reset_outputs("reset");

    // 1: release reset, sweep runs 16 cycles, then every register reads 0
    rst_n = 1'b1;
    idle(N);
    for (int i = 0; i < N; i++) cycle(SW'(i), SW'(i), SW'(N - 1 - i), '0, '0, 1'b0, 1'b0);

    // 2: write r5, read it back on port A
    cycle('0, '0, '0, 4'd5, 32'hDEADBEEF, 1'b1, 1'b0);
    cycle(4'd5, 4'd5, '0, '0, '0, 1'b0, 1'b0);

    // 3: write to r0 is discarded without a dropped pulse
    cycle('0, '0, '0, 4'd0, 32'h00001234, 1'b1, 1'b0);
    cycle('0, 4'd0, '0, '0, '0, 1'b0, 1'b0);

    // 4: same-edge read and write of r3
    cycle('0, '0, '0, 4'd3, 32'h11111111, 1'b1, 1'b0);
    cycle(4'd3, 4'd3, 4'd3, 4'd3, 32'hA5A5A5A5, 1'b1, 1'b0);
    cycle('0, '0, 4'd3, '0, '0, 1'b0, 1'b0);

    // 5: clear_req wins over a same-cycle write; r7 ends up zero
    cycle('0, '0, '0, 4'd7, 32'h0BADF00D, 1'b1, 1'b0);
    cycle(4'd7, '0, '0, 4'd7, 32'h00000001, 1'b1, 1'b1);
    cycle('0, '0, '0, 4'd9, 32'h12345678, 1'b1, 1'b1);  // dropped, clear_req ignored
    idle(N - 1);
    cycle(4'd7, 4'd9, 4'd5, '0, '0, 1'b0, 1'b0);

    // 6: reset mid-sweep at clear_idx 8, held for two cycles
    cycle('0, '0, '0, 4'd2, 32'hCAFE0002, 1'b1, 1'b0);
    cycle('0, '0, '0, '0, '0, 1'b0, 1'b1);
    idle(8);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midsweep_reset");
    @(negedge clk);
    @(negedge clk);
    model_reset();
    rst_n = 1'b1;
    idle(N + 1);
    cycle(4'd2, 4'd5, 4'd3, '0, '0, 1'b0, 1'b0);

    // randomized traffic with occasional clear requests
    for (int i = 0; i < 600; i++) begin
      cycle(SW'($urandom_range(0, N - 1)), SW'($urandom_range(0, N - 1)),
            SW'($urandom_range(0, N - 1)), SW'($urandom_range(0, N - 1)),
            $urandom(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 59) == 0));
    end
    idle(2);

    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
